// File: rtl/gate_tt_pkg.sv
// Shared types and reference truth tables for the 2-input gate-cell checker.
// Truth tables are indexed by the input vector {a,b}: bit i is the expected output for vector i.
package gate_tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] NOR_TT  = 4'b0001;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] XOR_TT  = 4'b0110;
    localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_tt_checker.sv
// Truth-table sequencer/checker: steps every input vector into a gate cell, waits a settle
// time, samples the gate output against EXP_TT and reports per-vector failures.
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int               N_IN       = 2,
    parameter logic [(2**N_IN)-1:0] EXP_TT = NAND_TT,
    parameter int               SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      gate_in,
    input  logic                 gate_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [(2**N_IN)-1:0] fail_vec
);

    localparam int              NV       = 2 ** N_IN;
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);

    state_t          state;
    logic [N_IN-1:0] vec;
    logic [3:0]      cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            cnt       <= '0;
            gate_in   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SETTLE;
                        vec       <= '0;
                        gate_in   <= '0;
                        cnt       <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    // Written as equal-else so an X/Z on gate_y falls into the mismatch branch.
                    if (gate_y == EXP_TT[vec]) begin
                    end else begin
                        err_count     <= err_count + (N_IN+1)'(1);
                        fail_vec[vec] <= 1'b1;
                    end
                    if (vec == VEC_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        vec     <= vec + N_IN'(1);
                        gate_in <= vec + N_IN'(1);
                        cnt     <= '0;
                        state   <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
Self-running truth-table sequencer and checker for the team's 2-input universal/basic gate cells (nand_gate and siblings). It drives every input vector into the gate under test and waits a programmable settle time. It then samples the gate output, compares it against a parameterised expected truth table, and reports pass/fail with per-vector failure flags. It sits directly upstream of the gate (feeds its inputs) and downstream of it (consumes its output), replacing hand-written #delay stimulus in gate benches.

Parameters:
N_IN, 2, number of gate inputs; vector count NV = 2**N_IN
EXP_TT, 4'b0111 (NAND), expected output; bit i = expected gate_y for vector i; width NV
SETTLE_CYC, 2, clock cycles each vector is held before sampling; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle run request; honoured only in IDLE
gate_in  output  N_IN  vector driven to the gate; gate_in[1]=a, gate_in[0]=b for N_IN=2
gate_y  input  1  gate output under test (combinational from gate_in)
busy  output  1  high in SETTLE and SAMPLE
done  output  1  one-cycle pulse when a run completes
pass  output  1  1 if the last run had zero mismatches; held until next accepted start
err_count  output  N_IN+1  mismatches in the last run (0..NV)
fail_vec  output  NV  bit i set if vector i mismatched

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low (clk, rst_n). All outputs registered.
- Reset values: state=IDLE, gate_in=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, vec index=0, settle count=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: start=1 -> SETTLE. Same edge: vec=0, gate_in=0, settle cnt=0, err_count=0, fail_vec=0, pass=0.
  - SETTLE: cnt increments each cycle. cnt==SETTLE_CYC-1 -> SAMPLE. gate_in is held stable for SETTLE_CYC cycles.
  - SAMPLE (1 cycle): compare gate_y to EXP_TT[vec].
    - Mismatch: err_count+1 and fail_vec[vec]=1.
    - vec==NV-1 -> DONE.
    - Otherwise vec+1, gate_in<=vec+1, cnt=0 -> SETTLE.
  - DONE (1 cycle): done=1; pass=(err_count==0), reflecting all NV compares -> IDLE.
- Compare rule: code it as "if (gate_y == expected) ok; else mismatch". An X/Z on gate_y must count as a mismatch in simulation.
- Latency: done is high in cycle NV*(SETTLE_CYC+1)+1 after the start-accepting edge. Defaults: 13 (edge 13).
- gate_in keeps the last vector (NV-1) after a run until the next start or reset.
- start while busy or in DONE: ignored, with no effect on the run.
- start held high: retriggers on the first IDLE cycle after DONE. A new run clears err_count, fail_vec and pass.
- Reset mid-run: all outputs go to reset values immediately. No done pulse is produced. The next start runs normally.
- err_count cannot overflow: its max is NV, and its width is N_IN+1.

Decomposition:
- Shared package gate_tt_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE)
  - 2-input truth-table constants: NAND_TT=4'b0111, NOR_TT=4'b0001, AND_TT=4'b1000, OR_TT=4'b1110, XOR_TT=4'b0110, XNOR_TT=4'b1001
- Single module; the settle counter and vector counter are inline.
- No sub-module. The bench instantiates nand_gate (and other cells) as the DUT fed by gate_in.

Test Plan:
1. Reset; start at edge 0 with nand_gate attached and defaults -> gate_in steps 00,01,10,11, each held 3 cycles; done pulse at edge 13; pass=1, err_count=0, fail_vec=4'b0000.
2. and-style gate with EXP_TT=NAND_TT -> err_count=4, fail_vec=4'b1111, pass=0.
3. gate_y tied 1 (stuck-at-1) with NAND_TT -> err_count=1, fail_vec=4'b1000, pass=0.
4. start pulsed again at edges 4 and 12 -> ignored; exactly one done at edge 13. start at edge 14 -> clean second run, counters cleared at edge 14, done at edge 27.
5. rst_n low at edge 6 (mid-run) -> busy=0, gate_in=0, err_count=0 asynchronously, no done. Release, then start -> full pass run.
6. gate_y forced X on vector 2 -> fail_vec=4'b0100, err_count=1. With SETTLE_CYC=1 and a correct gate -> done at edge 9, pass=1.
